// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: load funct3 codes and the write-back bus bundle.
// Used by the MA, EX and WB stages.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    typedef struct packed {
        logic            en;
        logic [4:0]      adr;
        logic [XLEN-1:0] data;
    } wbk_bus_t;

endpackage

// File: rtl/wb_stage_if.sv
// MA->WB pipeline inputs, ID read ports and the WB forwarding buses.
// master = upstream/consumers side, slave = the write-back stage.
interface wb_stage_if;

    logic        cmd_ld_wb;
    logic [2:0]  ld_code_wb;
    logic [4:0]  rd_adr_wb;
    logic [31:0] rd_data_wb;
    logic        wbk_rd_reg_wb;
    logic [31:0] ld_data_wb;
    logic        stall;
    logic        rst_pipe;
    logic [4:0]  inst_rs1;
    logic [4:0]  inst_rs2;
    logic [31:0] rs1_data_rf;
    logic [31:0] rs2_data_rf;
    logic        wbk_en;
    logic [4:0]  wbk_rd_adr;
    logic [31:0] wbk_data;
    logic        wbk_en_dly;
    logic [4:0]  wbk_rd_adr_dly;
    logic [31:0] wbk_data_dly;

    modport master (
        output cmd_ld_wb, ld_code_wb, rd_adr_wb, rd_data_wb,
        output wbk_rd_reg_wb, ld_data_wb, stall, rst_pipe,
        output inst_rs1, inst_rs2,
        input  rs1_data_rf, rs2_data_rf,
        input  wbk_en, wbk_rd_adr, wbk_data,
        input  wbk_en_dly, wbk_rd_adr_dly, wbk_data_dly
    );

    modport slave (
        input  cmd_ld_wb, ld_code_wb, rd_adr_wb, rd_data_wb,
        input  wbk_rd_reg_wb, ld_data_wb, stall, rst_pipe,
        input  inst_rs1, inst_rs2,
        output rs1_data_rf, rs2_data_rf,
        output wbk_en, wbk_rd_adr, wbk_data,
        output wbk_en_dly, wbk_rd_adr_dly, wbk_data_dly
    );

endinterface

// File: rtl/reg_file.sv
// RV32I integer register file: x1..x31 flops, x0 hardwired to zero.
// One write port, two asynchronous read ports with write-through bypass.
module reg_file
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_we,
    input  logic [4:0]      i_wr_adr,
    input  logic [XLEN-1:0] i_wr_data,
    input  logic [4:0]      i_rs1_adr,
    input  logic [4:0]      i_rs2_adr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data
);

    logic [XLEN-1:0] r_regs [1:NREG-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_wr_adr != 5'd0)) begin
            r_regs[i_wr_adr] <= i_wr_data;
        end
    end

    // Bypass lets ID see the value being written in the same cycle.
    always_comb begin
        o_rs1_data = '0;
        if (i_rs1_adr == 5'd0) begin
            o_rs1_data = '0;
        end else if (i_we && (i_rs1_adr == i_wr_adr)) begin
            o_rs1_data = i_wr_data;
        end else begin
            o_rs1_data = r_regs[i_rs1_adr];
        end
    end

    always_comb begin
        o_rs2_data = '0;
        if (i_rs2_adr == 5'd0) begin
            o_rs2_data = '0;
        end else if (i_we && (i_rs2_adr == i_wr_adr)) begin
            o_rs2_data = i_wr_data;
        end else begin
            o_rs2_data = r_regs[i_rs2_adr];
        end
    end

endmodule

// File: rtl/wb_stage.sv
// RV32I write-back stage: load aligner, register file and the
// current/one-cycle-delayed write-back buses for EX forwarding.
module wb_stage
    import rv32i_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    wb_stage_if.slave  bus
);

    logic [1:0]      w_ofs;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_ld_align;
    logic            w_wbk_en;
    logic [XLEN-1:0] w_wbk_data;
    wbk_bus_t        r_dly;

    assign w_ofs  = bus.rd_data_wb[1:0];
    assign w_half = bus.rd_data_wb[1] ? bus.ld_data_wb[31:16]
                                      : bus.ld_data_wb[15:0];

    always_comb begin
        w_byte = bus.ld_data_wb[7:0];
        case (w_ofs)
            2'd0:    w_byte = bus.ld_data_wb[7:0];
            2'd1:    w_byte = bus.ld_data_wb[15:8];
            2'd2:    w_byte = bus.ld_data_wb[23:16];
            default: w_byte = bus.ld_data_wb[31:24];
        endcase
    end

    always_comb begin
        w_ld_align = '0;
        case (bus.ld_code_wb)
            LD_LB:   w_ld_align = {{24{w_byte[7]}}, w_byte};
            LD_LH:   w_ld_align = {{16{w_half[15]}}, w_half};
            LD_LW:   w_ld_align = bus.ld_data_wb;
            LD_LBU:  w_ld_align = {24'd0, w_byte};
            LD_LHU:  w_ld_align = {16'd0, w_half};
            default: w_ld_align = '0;
        endcase
    end

    assign w_wbk_data = bus.cmd_ld_wb ? w_ld_align : bus.rd_data_wb;

    // MA holds the instruction during stall, so gating here writes it once.
    assign w_wbk_en = bus.wbk_rd_reg_wb & ~bus.stall & ~bus.rst_pipe
                    & (bus.rd_adr_wb != 5'd0);

    assign bus.wbk_en     = w_wbk_en;
    assign bus.wbk_rd_adr = bus.rd_adr_wb;
    assign bus.wbk_data   = w_wbk_data;

    reg_file u_reg_file (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_wbk_en),
        .i_wr_adr   (bus.rd_adr_wb),
        .i_wr_data  (w_wbk_data),
        .i_rs1_adr  (bus.inst_rs1),
        .i_rs2_adr  (bus.inst_rs2),
        .o_rs1_data (bus.rs1_data_rf),
        .o_rs2_data (bus.rs2_data_rf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly <= '0;
        end else if (bus.rst_pipe) begin
            r_dly <= '0;
        end else begin
            r_dly <= '{en: w_wbk_en, adr: bus.rd_adr_wb, data: w_wbk_data};
        end
    end

    assign bus.wbk_en_dly     = r_dly.en;
    assign bus.wbk_rd_adr_dly = r_dly.adr;
    assign bus.wbk_data_dly   = r_dly.data;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: behavioural reference model compared
// every cycle, plus hand-computed literal expectations.
module tb_wb_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;
    bit   checking = 1'b0;

    logic [31:0] m_rf [0:31];
    logic        m_dly_en;
    logic [4:0]  m_dly_adr;
    logic [31:0] m_dly_data;

    wb_stage_if bus ();

    wb_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    function automatic logic [31:0] m_load(input logic [2:0] code,
                                           input logic [31:0] addr,
                                           input logic [31:0] w);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * addr[1:0])) & 32'hFF;
        h = (w >> (16 * addr[1])) & 32'hFFFF;
        case (code)
            3'b000: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'b001: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'b010: return w;
            3'b100: return b;
            3'b101: return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_en();
        return bus.wbk_rd_reg_wb && !bus.stall && !bus.rst_pipe
            && (bus.rd_adr_wb != 0);
    endfunction

    function automatic logic [31:0] m_data();
        return bus.cmd_ld_wb
            ? m_load(bus.ld_code_wb, bus.rd_data_wb, bus.ld_data_wb)
            : bus.rd_data_wb;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (m_en() && a == bus.rd_adr_wb) return m_data();
        return m_rf[a];
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_dly_en = 0;
        m_dly_adr = 0;
        m_dly_data = 0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_rf[i] <= '0;
            m_dly_en <= 0;
            m_dly_adr <= 0;
            m_dly_data <= 0;
        end else begin
            if (m_en()) m_rf[bus.rd_adr_wb] <= m_data();
            if (bus.rst_pipe) begin
                m_dly_en <= 0;
                m_dly_adr <= 0;
                m_dly_data <= 0;
            end else begin
                m_dly_en <= m_en();
                m_dly_adr <= bus.rd_adr_wb;
                m_dly_data <= m_data();
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("m_wbk_en", {31'd0, bus.wbk_en}, {31'd0, m_en()});
            chk("m_wbk_adr", {27'd0, bus.wbk_rd_adr}, {27'd0, bus.rd_adr_wb});
            chk("m_wbk_data", bus.wbk_data, m_data());
            chk("m_rs1", bus.rs1_data_rf, m_read(bus.inst_rs1));
            chk("m_rs2", bus.rs2_data_rf, m_read(bus.inst_rs2));
            chk("m_dly_en", {31'd0, bus.wbk_en_dly}, {31'd0, m_dly_en});
            chk("m_dly_adr", {27'd0, bus.wbk_rd_adr_dly}, {27'd0, m_dly_adr});
            chk("m_dly_data", bus.wbk_data_dly, m_dly_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [2:0] code,
                         input logic [4:0] rd, input logic [31:0] d,
                         input logic wbk, input logic [31:0] ldw);
        bus.cmd_ld_wb = ld;
        bus.ld_code_wb = code;
        bus.rd_adr_wb = rd;
        bus.rd_data_wb = d;
        bus.wbk_rd_reg_wb = wbk;
        bus.ld_data_wb = ldw;
    endtask

    typedef struct {
        logic [2:0]  code;
        logic [31:0] addr;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t ld_tab [6];

    initial begin
        ld_tab[0] = '{3'b000, 32'h100, 32'hFFFF_FFBB};
        ld_tab[1] = '{3'b100, 32'h103, 32'h0000_0088};
        ld_tab[2] = '{3'b001, 32'h102, 32'hFFFF_8899};
        ld_tab[3] = '{3'b101, 32'h100, 32'h0000_AABB};
        ld_tab[4] = '{3'b010, 32'h100, 32'h8899_AABB};
        ld_tab[5] = '{3'b011, 32'h100, 32'h0000_0000};

        drive(1'b1, 3'b000, 5'd3, 32'hCAFE_0001, 1'b1, 32'hFFFF_FFFF);
        bus.stall = 1'b0;
        bus.rst_pipe = 1'b0;
        bus.inst_rs1 = 5'd0;
        bus.inst_rs2 = 5'd0;
        #2 rst_n = 1'b0;
        checking = 1'b1;
        repeat (3) tick();
        chk("rst_dly_en", {31'd0, bus.wbk_en_dly}, 32'd0);
        chk("rst_dly_data", bus.wbk_data_dly, 32'd0);
        chk("rst_dly_adr", {27'd0, bus.wbk_rd_adr_dly}, 32'd0);

        drive(1'b0, 3'b000, 5'd0, 32'd0, 1'b0, 32'd0);
        #1;
        chk("rst_wbk_en", {31'd0, bus.wbk_en}, 32'd0);
        chk("rst_wbk_data", bus.wbk_data, 32'd0);
        for (int i = 1; i < 32; i++) begin
            bus.inst_rs1 = 5'(i);
            #1;
            chk("rst_rf", bus.rs1_data_rf, 32'd0);
        end
        tick();
        rst_n = 1'b1;
        tick();

        foreach (ld_tab[k]) begin
            drive(1'b1, ld_tab[k].code, 5'd5, ld_tab[k].addr, 1'b1,
                  32'h8899_AABB);
            bus.inst_rs1 = 5'd5;
            #1;
            chk("ld_bypass", bus.rs1_data_rf, ld_tab[k].exp);
            tick();
            bus.wbk_rd_reg_wb = 1'b0;
            #1;
            chk("ld_array", bus.rs1_data_rf, ld_tab[k].exp);
            tick();
        end

        drive(1'b0, 3'b000, 5'd0, 32'h1234, 1'b1, 32'd0);
        bus.inst_rs1 = 5'd0;
        #1;
        chk("x0_wbk_en", {31'd0, bus.wbk_en}, 32'd0);
        chk("x0_read", bus.rs1_data_rf, 32'd0);
        tick();
        #1;
        chk("x0_after", bus.rs1_data_rf, 32'd0);

        drive(1'b0, 3'b000, 5'd7, 32'hDEAD_BEEF, 1'b1, 32'd0);
        bus.inst_rs1 = 5'd7;
        bus.inst_rs2 = 5'd7;
        #1;
        chk("x7_byp_rs1", bus.rs1_data_rf, 32'hDEAD_BEEF);
        chk("x7_byp_rs2", bus.rs2_data_rf, 32'hDEAD_BEEF);
        tick();
        bus.wbk_rd_reg_wb = 1'b0;
        #1;
        chk("x7_arr_rs1", bus.rs1_data_rf, 32'hDEAD_BEEF);
        chk("x7_arr_rs2", bus.rs2_data_rf, 32'hDEAD_BEEF);
        tick();

        drive(1'b0, 3'b000, 5'd9, 32'h55, 1'b1, 32'd0);
        bus.stall = 1'b1;
        bus.inst_rs1 = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_en", {31'd0, bus.wbk_en}, 32'd0);
            chk("stall_rf", bus.rs1_data_rf, 32'd0);
            tick();
            chk("stall_dly", {31'd0, bus.wbk_en_dly}, 32'd0);
        end
        bus.stall = 1'b0;
        #1;
        chk("unstall_en", {31'd0, bus.wbk_en}, 32'd1);
        tick();
        bus.wbk_rd_reg_wb = 1'b0;
        #1;
        chk("unstall_dly_en", {31'd0, bus.wbk_en_dly}, 32'd1);
        chk("unstall_dly_data", bus.wbk_data_dly, 32'h55);
        chk("unstall_x9", bus.rs1_data_rf, 32'h55);
        tick();

        drive(1'b0, 3'b000, 5'd3, 32'h33, 1'b1, 32'd0);
        tick();
        drive(1'b0, 3'b000, 5'd3, 32'hA5, 1'b1, 32'd0);
        bus.rst_pipe = 1'b1;
        bus.inst_rs1 = 5'd3;
        bus.inst_rs2 = 5'd9;
        #1;
        chk("flush_en", {31'd0, bus.wbk_en}, 32'd0);
        tick();
        bus.rst_pipe = 1'b0;
        bus.wbk_rd_reg_wb = 1'b0;
        #1;
        chk("flush_dly_en", {31'd0, bus.wbk_en_dly}, 32'd0);
        chk("flush_dly_data", bus.wbk_data_dly, 32'd0);
        chk("flush_x3", bus.rs1_data_rf, 32'h33);
        chk("flush_x9", bus.rs2_data_rf, 32'h55);
        tick();

        drive(1'b0, 3'b000, 5'd8, 32'h88, 1'b1, 32'd0);
        tick();
        bus.stall = 1'b1;
        bus.rst_pipe = 1'b1;
        tick();
        bus.stall = 1'b0;
        bus.rst_pipe = 1'b0;
        bus.wbk_rd_reg_wb = 1'b0;
        #1;
        chk("both_dly_data", bus.wbk_data_dly, 32'd0);
        tick();

        drive(1'b0, 3'b000, 5'd4, 32'd1, 1'b1, 32'd0);
        tick();
        drive(1'b0, 3'b000, 5'd4, 32'd2, 1'b1, 32'd0);
        #1;
        chk("b2b_dly", bus.wbk_data_dly, 32'd1);
        chk("b2b_cur", bus.wbk_data, 32'd2);
        tick();
        bus.wbk_rd_reg_wb = 1'b0;
        bus.inst_rs1 = 5'd4;
        #1;
        chk("b2b_x4", bus.rs1_data_rf, 32'd2);
        tick();

        rst_n = 1'b0;
        #1;
        chk("async_rst_x4", bus.rs1_data_rf, 32'd0);
        drive(1'b0, 3'b000, 5'd6, 32'h66, 1'b1, 32'd0);
        bus.inst_rs1 = 5'd6;
        bus.inst_rs2 = 5'd4;
        #1 rst_n = 1'b1;
        tick();
        bus.wbk_rd_reg_wb = 1'b0;
        #1;
        chk("post_rst_x6", bus.rs1_data_rf, 32'h66);
        chk("post_rst_x4", bus.rs2_data_rf, 32'd0);
        tick();
        tick();

        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
